mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The ports SHALL be `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The ports SHALL include `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The ports SHALL include `start`, input, 1 bit: operation request, sampled only in IDLE.
REQ-004 The ports SHALL include `op`, input, 1 bit: 0 = signed multiply (mult), 1 = signed divide (div).
REQ-005 The ports SHALL include `a`, input, 32 bits: multiplicand or dividend (register A of the datapath).
REQ-006 The ports SHALL include `b`, input, 32 bits: multiplier or divisor (register B of the datapath).
REQ-007 The ports SHALL include `hi`, output, 32 bits: mult upper product word or div remainder; feeds the HI register input mux.
REQ-008 The ports SHALL include `lo`, output, 32 bits: mult lower product word or div quotient; feeds the LO register input mux.
REQ-009 The ports SHALL include `busy`, output, 1 bit: high while in CALC.
REQ-010 The ports SHALL include `done`, output, 1 bit: one-cycle completion pulse.
REQ-011 The ports SHALL include `div_zero`, output, 1 bit: one-cycle divide-by-zero exception pulse, coincident with `done`.

Function
REQ-012 The block SHALL be the responder to the control unit's mult/div request: the control unit raises `start`, waits for `done`, then writes HI/LO.
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 In IDLE, if `start` is 1 at a rising edge N, the block SHALL latch `a`, `b` and `op`, clear the iteration counter to 0, and enter CALC.
REQ-015 Exception: if `start`=1, `op`=1 and `b`=0 at edge N, the block SHALL go directly to DONE, assert `div_zero`, and leave `hi`/`lo` unchanged.
REQ-016 CALC SHALL run exactly 32 iterations, one per edge from N+1 to N+32, using a 6-bit counter; at edge N+32 it SHALL update `hi`/`lo` and enter DONE.
REQ-017 `done` SHALL be 1 only in DONE, which lasts one cycle, between edges N+32 and N+33; DONE SHALL return to IDLE unconditionally.
REQ-018 In the divide-by-zero case, DONE SHALL occupy the cycle between edges N and N+1.
REQ-019 mult SHALL use Booth radix-2 on a 65-bit {acc, multiplier, q-1} register, and the result SHALL be the exact signed 64-bit product: `hi` = [63:32], `lo` = [31:0].
REQ-020 div SHALL use restoring division on operand magnitudes; `lo` SHALL be the quotient truncated toward zero, and `hi` SHALL be the remainder carrying the sign of the dividend.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL give `lo` = 0x80000000 and `hi` = 0x00000000, with no exception.
REQ-022 `hi`/`lo` SHALL hold their last completed result until the next successful completion; intermediate values SHALL NOT appear on `hi`/`lo`.
REQ-023 `start` SHALL be ignored in CALC and DONE; operand changes during CALC SHALL NOT affect the result.
REQ-024 `busy`, `done` and `div_zero` SHALL be registered-state decodes, free of combinational paths from the inputs.

Reset
REQ-025 When `reset`=1, the block SHALL immediately, without waiting for a clock edge, enter IDLE and force `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, and the counter and internal registers to 0.
REQ-026 A reset asserted mid-CALC SHALL abort the operation, and no `done` SHALL follow.
REQ-027 After reset deassertion, a `start` SHALL be accepted at the first rising edge on which `reset`=0.

Verification
REQ-028 Scenario: mult, a=3, b=0xFFFFFFFE -> `done` high 32 cycles after the start edge; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA; `div_zero`=0.
REQ-029 Scenario: mult, a=b=0x7FFFFFFF -> `hi`=0x3FFFFFFF, `lo`=0x00000001; mult, a=b=0x80000000 -> `hi`=0x40000000, `lo`=0.
REQ-030 Scenario: div, a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; div, a=7, b=0xFFFFFFFE -> `lo`=0xFFFFFFFD, `hi`=1; div, a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
REQ-031 Scenario: preload `hi`=5, `lo`=9 via a prior op, then div with b=0 -> `done`=`div_zero`=1 the cycle after the start edge; `hi`=5, `lo`=9 unchanged; `busy` never 1.
REQ-032 Scenario: `start` re-pulsed with new operands at cycle 10 of CALC -> ignored; exactly one `done`, carrying the original result.
REQ-033 Scenario: reset asserted at cycle 15 of CALC, asynchronously between edges -> outputs 0 before the next edge; no `done` within 40 cycles; a new mult 6*7 then gives `lo`=42, `hi`=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: Booth radix-2 multiply and restoring
// divide on magnitudes, one iteration per clock over 32 cycles.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic        r_op;
  logic        r_sa;
  logic        r_sb;
  logic        r_qm1;
  logic        r_dz;
  logic [31:0] r_acc;
  logic [31:0] r_q;
  logic [31:0] r_m;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [32:0] w_bsum;
  logic [33:0] w_dif;
  logic [31:0] w_acc_n;
  logic [31:0] w_q_n;
  logic        w_qm1_n;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a divide by zero skips CALC entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op && (b == 32'd0)) begin
            w_next = S_DONE;
          end else begin
            w_next = S_CALC;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == 6'd31) begin
          w_next = S_DONE;
        end else begin
          w_next = S_CALC;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One iteration step; the Booth add uses a 33-bit sum so the -2^31 operand stays exact
  always_comb begin
    w_bsum  = {r_acc[31], r_acc};
    w_dif   = {1'b0, r_acc, r_q[31]} - {2'b00, r_m};
    w_acc_n = r_acc;
    w_q_n   = r_q;
    w_qm1_n = r_qm1;
    if (r_op == 1'b0) begin
      case ({r_q[0], r_qm1})
        2'b01:   w_bsum = {r_acc[31], r_acc} + {r_m[31], r_m};
        2'b10:   w_bsum = {r_acc[31], r_acc} - {r_m[31], r_m};
        default: w_bsum = {r_acc[31], r_acc};
      endcase
      w_acc_n = w_bsum[32:1];
      w_q_n   = {w_bsum[0], r_q[31:1]};
      w_qm1_n = r_q[0];
    end else if (w_dif[33] == 1'b0) begin
      w_acc_n = w_dif[31:0];
      w_q_n   = {r_q[30:0], 1'b1};
      w_qm1_n = 1'b0;
    end else begin
      w_acc_n = {r_acc[30:0], r_q[31]};
      w_q_n   = {r_q[30:0], 1'b0};
      w_qm1_n = 1'b0;
    end
  end

  assign w_quo    = (r_sa ^ r_sb) ? (32'd0 - w_q_n) : w_q_n;
  assign w_rem    = r_sa ? (32'd0 - w_acc_n) : w_acc_n;
  assign w_res_hi = r_op ? w_rem : w_acc_n;
  assign w_res_lo = r_op ? w_quo : w_q_n;

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 6'd0;
      r_op  <= 1'b0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_qm1 <= 1'b0;
      r_dz  <= 1'b0;
      r_acc <= 32'd0;
      r_q   <= 32'd0;
      r_m   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dz <= 1'b0;
          if (start) begin
            r_op  <= op;
            r_cnt <= 6'd0;
            r_sa  <= a[31];
            r_sb  <= b[31];
            r_qm1 <= 1'b0;
            r_acc <= 32'd0;
            if (op) begin
              r_q <= a[31] ? (32'd0 - a) : a;
              r_m <= b[31] ? (32'd0 - b) : b;
              r_dz <= (b == 32'd0);
            end else begin
              r_q <= b;
              r_m <= a;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_qm1 <= w_qm1_n;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        S_DONE: begin
          r_dz <= 1'b0;
        end
        default: begin
          r_dz <= 1'b0;
        end
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state == S_CALC);
  assign done     = (r_state == S_DONE);
  assign div_zero = r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a plain-arithmetic
// reference model (64-bit signed product, truncating divide, dividend-signed remainder).
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: updates expected hi/lo, returns the expected exception flag
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y, output logic dz);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    if (o == 1'b0) begin
      p = sx * sy;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (sy == 0) begin
      dz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input int repulse_at);
    logic dz;
    int   lat;
    int   mid_changes;
    int   extra_done;
    logic saw_busy;
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi;
    old_lo = exp_lo;
    model(o, x, y, dz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
    lat = 0;
    mid_changes = 0;
    saw_busy = busy;
    while (!done && lat < 40) begin
      if (hi !== old_hi || lo !== old_lo) mid_changes++;
      if (repulse_at > 0 && lat == repulse_at) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      saw_busy = saw_busy | busy;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), dz ? 64'd0 : 64'd32);
    check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, dz});
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, " hold"}, 64'(mid_changes), 64'd0);
    check({tag, " busy"}, {63'd0, dz ? saw_busy : busy}, 64'd0);
    @(posedge clk); #1;
    check({tag, " pulse"}, {62'd0, done, div_zero}, 64'd0);
    if (repulse_at > 0) begin
      extra_done = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done) extra_done++;
      end
      check({tag, " no_extra_done"}, 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    int dcount;
    logic [31:0] rx, ry;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outs", {hi, lo}, 64'd0);
    check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b0;
    // start at the very first edge after release
    run_op("m3x-2", 1'b0, 32'd3, 32'hFFFFFFFE, 0);
    run_op("mmaxpos", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
    run_op("mminneg", 1'b0, 32'h80000000, 32'h80000000, 0);
    run_op("d-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run_op("d7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_op("dmin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("preload", 1'b1, 32'd95, 32'd10, 0);
    check("preload val", {hi, lo}, {32'd5, 32'd9});
    run_op("dzero", 1'b1, 32'd1234, 32'd0, 0);
    run_op("repulse", 1'b0, 32'h12345678, 32'hFEDCBA98, 10);

    // async reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'hDEADBEEF; b = 32'h00C0FFEE;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async rst outs", {hi, lo}, 64'd0);
    check("async rst flags", {61'd0, busy, done, div_zero}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort no done", 64'(dcount), 64'd0);
    run_op("m6x7", 1'b0, 32'd6, 32'd7, 0);

    for (int k = 0; k < 40; k++) begin
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 5))
        0: rx = 32'h80000000;
        1: ry = 32'hFFFFFFFF;
        2: ry = 32'(signed'($urandom_range(0, 16)) - 8);
        default: rx = rx;
      endcase
      run_op($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), rx, ry, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
